// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, 8N1 framing constants
// and the baud divisor helpers.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   DATA_BITS      = 8;
    localparam int   MIN_BAUD_CNT_W = 17;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Keep the baud counter wide enough for slow line rates.
    function automatic int baud_cnt_w(input int div);
        return ($clog2(div) > MIN_BAUD_CNT_W) ? $clog2(div) : MIN_BAUD_CNT_W;
    endfunction
endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 serializer: takes a byte on load while idle, shifts it out LSB first
// framed by a start and a stop bit, each bit held for BAUD_DIV clocks.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);
    localparam int            CW        = baud_cnt_w(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    uart_state_e   state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != IDLE);
    assign done    = (state == STOP) && bit_end;

    // tx is updated on the same edge as the state so the line is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= STOP_BIT;
        end else begin
            baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: if (load) begin
                    state <= START;
                    shreg <= data;
                    tx    <= START_BIT;
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    tx      <= shreg[0];
                end
                DATA: if (bit_end) begin
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state <= STOP;
                        tx    <= STOP_BIT;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= shreg >> 1;
                        tx      <= shreg[1];
                    end
                end
                STOP: if (bit_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line between NUM_REQ byte streams;
// an owner keeps the line for a whole message unless it stalls too long.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       UART_TX
);
    localparam int IDW      = $clog2(NUM_REQ);
    localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int TW       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic [IDW-1:0] rr_ptr, sel;
    logic [TW-1:0]  to_cnt;
    logic [7:0]     sel_byte;
    logic           locked, ser_busy, ser_done, xfer, to_wait;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] pick;
        int             s;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (v[IDW'(s)]) pick = IDW'(s);
        end
        return pick;
    endfunction

    assign sel      = locked ? grant_id : rr_pick(req_valid, rr_ptr);
    assign sel_byte = req_data[{sel, 3'b000} +: 8];
    assign xfer     = req_valid[sel] && !ser_busy;
    assign busy     = ser_busy || locked;
    assign to_wait  = (LOCK_TIMEOUT != 0) && !ser_busy && locked && !req_valid[grant_id];

    always_comb begin
        req_ready      = '0;
        req_ready[sel] = xfer;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            grant_id <= '0;
            to_cnt   <= '0;
        end else if (xfer) begin
            grant_id <= sel;
            locked   <= !req_last[sel];
            to_cnt   <= '0;
        end else if (ser_done) begin
            if (!locked) rr_ptr <= wrap_inc(grant_id);
        end else if (to_wait) begin
            // Stalled owner: drop the lock and let the others in.
            if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                locked <= 1'b0;
                rr_ptr <= wrap_inc(grant_id);
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    uart_tx_ser #(.BAUD_DIV(BAUD_DIV)) u_ser (
        .clk  (CLOCK_50),
        .rst  (reset),
        .load (xfer),
        .data (sel_byte),
        .busy (ser_busy),
        .done (ser_done),
        .tx   (UART_TX)
    );
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single board UART_TX pin between NUM_REQ byte-stream requesters, such as the LED status reporter and the RND_OUT random-number dumper.
- Round-robin arbitration with message locking: once a requester starts a message, it keeps the line until it sends its last byte.
- Drives an 8N1 serializer at a fixed baud rate.
- Sits between the top-level producers and the UART_TX pin of the blinky top.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- CLK_HZ, 50_000_000: CLOCK_50 frequency.
- BAUD, 115200: line rate. Derived constant BAUD_DIV = CLK_HZ/BAUD, which is 434 at the defaults.
- LOCK_TIMEOUT, 65535: idle cycles a locked owner may stall before its lock is dropped. 0 disables the timeout.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  byte i is at [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of its message.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- grant_id  out  clog2(NUM_REQ)  current or most recent owner.
- busy  out  1  high when state != IDLE or a lock is held.
- UART_TX  out  1  serial line; idles high; registered output.

Behaviour:
- Reset values (applied asynchronously):
  - UART_TX=1, req_ready=0, busy=0, grant_id=0.
  - rr_ptr=0, locked=0, state=IDLE, bit counter and baud counter cleared.
- States: IDLE, START, DATA, STOP.
- IDLE, selection:
  - If locked, the only candidate is the owner.
  - Otherwise, pick the first i with req_valid[i], scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[sel] is driven combinationally to 1 only when state==IDLE and req_valid[sel]=1.
- Transfer happens when req_valid[sel] and req_ready[sel] are both high. In that same cycle:
  - latch the byte into the shift register;
  - grant_id <= sel;
  - locked <= !req_last[sel];
  - clear the timeout counter;
  - state <= START.
- START: UART_TX=0 for BAUD_DIV cycles. The line falls on the cycle after the transfer (latency 1).
- DATA: 8 bits sent LSB first, each held for BAUD_DIV cycles.
- STOP: UART_TX=1 for BAUD_DIV cycles, then go to IDLE. If not locked at that point, rr_ptr <= grant_id+1, wrapping.
- Frame length is exactly 10*BAUD_DIV cycles. Minimum byte-to-byte accept spacing is 10*BAUD_DIV+1 cycles.
- Locking:
  - While locked, other requesters are starved even if valid. This is intentional and gives message atomicity.
  - The lock is released when the owner's byte with req_last=1 is accepted.
- Timeout (when LOCK_TIMEOUT != 0):
  - Count IDLE cycles while locked and the owner's req_valid=0.
  - When the count reaches LOCK_TIMEOUT: locked <= 0, rr_ptr <= owner+1. Arbitration proceeds normally from the next cycle.
  - Any accepted byte clears the counter.
- req_valid/req_data changes during START/DATA/STOP are ignored; ready stays low.
- A requester dropping valid before it is accepted is legal; no byte is taken.
- Baud counter runs 0..BAUD_DIV-1; it must be at least 17 bits wide for small baud rates.
- Reset mid-frame: UART_TX returns to 1 asynchronously, the partial byte is discarded, and the lock is cleared.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (IDLE/START/DATA/STOP);
  - a BAUD_DIV helper function;
  - the 8N1 framing constants: start bit 0, stop bit 1, 8 data bits.
- One sub-module, uart_tx_ser, covers the baud counter, shift register and bit count.
  - Interface: load/byte in, busy/done out, UART_TX out.
- uart_tx_arbiter keeps the round-robin pointer, the lock and timeout logic, and the ready/grant generation.

Test Plan:
Simulate with CLK_HZ=50_000_000 and BAUD=5_000_000, giving BAUD_DIV=10.
1. Reset: assert reset at t=3 (async, off-edge). Required: UART_TX=1, req_ready=0, busy=0, grant_id=0 immediately. Release reset, all valid low: the line stays high for 1000 cycles.
2. Single byte: req0 sends 0xA5 with last=1. Required:
   - req_ready[0] high for exactly 1 cycle;
   - UART_TX low for 10 cycles, then bits 1,0,1,0,0,1,0,1, each 10 cycles;
   - then high; busy=0 at cycle 101.
3. Round-robin: req0 and req2 held valid with single-byte messages, last=1, data 0x11 and 0x33. Required:
   - decoded frame order 0x11, 0x33, 0x11, 0x33;
   - grant_id alternates 0, 2;
   - req1 and req3 are never granted.
4. Lock: req1 sends 0x41, 0x42, 0x43 (last on 0x43) while req0 is valid throughout. Required: frames 0x41, 0x42, 0x43, then req0's byte; req_ready[0]=0 until the lock releases.
5. Timeout: set LOCK_TIMEOUT=20. req1 sends 0x55 with last=0, then drops valid; req0 is valid. Required: req_ready[0] rises exactly 20 idle cycles after the end of STOP, and busy stays high until then.
6. Reset mid-DATA: assert reset during bit 3 of 0xF0. Required:
   - UART_TX=1 within the same cycle, locked=0;
   - after release, a new 0x0F from req3 is framed correctly and 0xF0 is never completed.
